// File: rtl/fsm_control_param.sv
// Link-layer control FSM for one main FIFO plus NUM_VC VC and NUM_VC D FIFOs.
// It captures FIFO thresholds while in INIT, debounces the ACTIVE->IDLE
// transition, latches per-FIFO errors until the next init, and flags any
// zero threshold that was captured.
module fsm_control_param #(
  parameter int NUM_VC    = 2,
  parameter int MF_W      = 2,
  parameter int VC_W      = 4,
  parameter int D_W       = 2,
  parameter int IDLE_HOLD = 1,
  localparam int NF       = 1 + 2 * NUM_VC,
  localparam int UW       = MF_W + NUM_VC * (VC_W + D_W)
) (
  input  logic                   clk,
  input  logic                   reset_L,
  input  logic                   init,
  input  logic [MF_W-1:0]        umbral_MF,
  input  logic [NUM_VC*VC_W-1:0] umbral_VC,
  input  logic [NUM_VC*D_W-1:0]  umbral_D,
  input  logic [NF-1:0]          FIFO_error,
  input  logic [NF-1:0]          FIFO_empty,
  output logic [UW-1:0]          umbrales_I,
  output logic                   active_out,
  output logic                   idle_out,
  output logic                   error_out,
  output logic [NF-1:0]          error_fifo,
  output logic                   cfg_err,
  output logic [2:0]             state_out
);

  localparam logic [2:0] RESET  = 3'd0;
  localparam logic [2:0] INIT   = 3'd1;
  localparam logic [2:0] IDLE   = 3'd2;
  localparam logic [2:0] ACTIVE = 3'd3;
  localparam logic [2:0] ERROR  = 3'd4;

  // The counter only ever holds 0..IDLE_HOLD-1, so this width never wraps.
  localparam int CW = (IDLE_HOLD < 1) ? 1 : $clog2(IDLE_HOLD + 1);
  localparam logic [CW-1:0] HOLD_LAST = CW'(IDLE_HOLD - 1);

  logic [2:0]    state_reg, state_next;
  logic [UW-1:0] umb_reg, umb_next;
  logic [NF-1:0] err_fifo_reg, err_fifo_next;
  logic          cfg_err_reg, cfg_err_next;
  logic [CW-1:0] cnt_reg, cnt_next;

  logic [NUM_VC-1:0] vc_zero;
  logic [NUM_VC-1:0] d_zero;
  logic              thr_zero;
  logic              all_empty;
  logic              any_err;

  // Per-channel zero detection on the thresholds being captured this edge.
  generate
    for (genvar gi = 0; gi < NUM_VC; gi++) begin : g_zero
      assign vc_zero[gi] = (umbral_VC[gi*VC_W +: VC_W] == '0);
      assign d_zero[gi]  = (umbral_D[gi*D_W +: D_W] == '0);
    end
  endgenerate

  assign thr_zero  = (umbral_MF == '0) | (|vc_zero) | (|d_zero);
  assign all_empty = &FIFO_empty;
  assign any_err   = |FIFO_error;

  // Next-state logic: error beats init, init beats the empty-driven rules.
  always_comb begin
    state_next    = state_reg;
    umb_next      = umb_reg;
    err_fifo_next = err_fifo_reg;
    cfg_err_next  = cfg_err_reg;
    cnt_next      = '0;
    case (state_reg)
      RESET: begin
        state_next    = INIT;
        err_fifo_next = '0;
        cfg_err_next  = 1'b0;
      end
      INIT: begin
        umb_next = {umbral_MF, umbral_VC, umbral_D};
        if (any_err) begin
          state_next    = ERROR;
          err_fifo_next = err_fifo_reg | FIFO_error;
        end else if (!init) begin
          state_next   = IDLE;
          cfg_err_next = cfg_err_reg | thr_zero;
        end
      end
      IDLE: begin
        if (any_err) begin
          state_next    = ERROR;
          err_fifo_next = err_fifo_reg | FIFO_error;
        end else if (init) begin
          state_next    = INIT;
          err_fifo_next = '0;
          cfg_err_next  = 1'b0;
        end else if (!all_empty) begin
          state_next = ACTIVE;
        end
      end
      ACTIVE: begin
        if (any_err) begin
          state_next    = ERROR;
          err_fifo_next = err_fifo_reg | FIFO_error;
        end else if (init) begin
          state_next    = INIT;
          err_fifo_next = '0;
          cfg_err_next  = 1'b0;
        end else if (all_empty) begin
          if (cnt_reg == HOLD_LAST) begin
            state_next = IDLE;
          end else begin
            cnt_next = cnt_reg + CW'(1);
          end
        end
      end
      ERROR: begin
        err_fifo_next = err_fifo_reg | FIFO_error;
        if (init && !any_err) begin
          state_next    = INIT;
          err_fifo_next = '0;
          cfg_err_next  = 1'b0;
        end
      end
      default: state_next = RESET;
    endcase
  end

  // State and status registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_L) begin
      state_reg    <= RESET;
      umb_reg      <= '0;
      err_fifo_reg <= '0;
      cfg_err_reg  <= 1'b0;
      cnt_reg      <= '0;
    end else begin
      state_reg    <= state_next;
      umb_reg      <= umb_next;
      err_fifo_reg <= err_fifo_next;
      cfg_err_reg  <= cfg_err_next;
      cnt_reg      <= cnt_next;
    end
  end

  assign umbrales_I = umb_reg;
  assign error_fifo = err_fifo_reg;
  assign cfg_err    = cfg_err_reg;
  assign state_out  = state_reg;
  assign active_out = (state_reg == ACTIVE);
  assign idle_out   = (state_reg == IDLE);
  assign error_out  = (state_reg == ERROR);

endmodule

// File: tb/tb_fsm_control_param.sv
// Directed-vector bench for fsm_control_param with NUM_VC=2, IDLE_HOLD=3.
module tb_fsm_control_param;

  localparam logic [13:0] U1 = {2'b11, 8'hA5, 4'b1001};
  localparam logic [13:0] U2 = {2'b11, 8'h50, 4'b1001};

  logic        clk = 1'b0;
  logic        reset_L, init;
  logic [1:0]  umbral_MF;
  logic [7:0]  umbral_VC;
  logic [3:0]  umbral_D;
  logic [4:0]  FIFO_error, FIFO_empty;
  logic [13:0] umbrales_I;
  logic        active_out, idle_out, error_out, cfg_err;
  logic [4:0]  error_fifo;
  logic [2:0]  state_out;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  fsm_control_param #(.NUM_VC(2), .MF_W(2), .VC_W(4), .D_W(2), .IDLE_HOLD(3)) dut (
    .clk(clk), .reset_L(reset_L), .init(init),
    .umbral_MF(umbral_MF), .umbral_VC(umbral_VC), .umbral_D(umbral_D),
    .FIFO_error(FIFO_error), .FIFO_empty(FIFO_empty),
    .umbrales_I(umbrales_I), .active_out(active_out), .idle_out(idle_out),
    .error_out(error_out), .error_fifo(error_fifo), .cfg_err(cfg_err),
    .state_out(state_out)
  );

  typedef struct {
    logic        rl;
    logic        ini;
    logic [1:0]  mf;
    logic [7:0]  vc;
    logic [3:0]  d;
    logic [4:0]  fe;
    logic [4:0]  fm;
    logic [2:0]  es;
    logic [13:0] eu;
    logic [4:0]  eef;
    logic        ecfg;
  } vec_t;

  vec_t tbl[27];

  function automatic vec_t mk(logic rl, logic ini, logic [1:0] mf, logic [7:0] vc,
                              logic [3:0] d, logic [4:0] fe, logic [4:0] fm,
                              logic [2:0] es, logic [13:0] eu, logic [4:0] eef,
                              logic ecfg);
    vec_t v;
    v.rl = rl; v.ini = ini; v.mf = mf; v.vc = vc; v.d = d; v.fe = fe; v.fm = fm;
    v.es = es; v.eu = eu; v.eef = eef; v.ecfg = ecfg;
    return v;
  endfunction

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s step %0d: got %0h expected %0h", nm, idx, act, exp);
    end
  endtask

  // Drive one vector, clock it in, and compare one cycle later.
  task automatic run_vec(input vec_t v, input int idx);
    reset_L    = v.rl;
    init       = v.ini;
    umbral_MF  = v.mf;
    umbral_VC  = v.vc;
    umbral_D   = v.d;
    FIFO_error = v.fe;
    FIFO_empty = v.fm;
    @(posedge clk);
    #1;
    chk("state_out", idx, 32'(state_out), 32'(v.es));
    chk("umbrales_I", idx, 32'(umbrales_I), 32'(v.eu));
    chk("error_fifo", idx, 32'(error_fifo), 32'(v.eef));
    chk("cfg_err", idx, 32'(cfg_err), 32'(v.ecfg));
    chk("flags", idx, 32'({active_out, idle_out, error_out}),
        32'({v.es == 3'd3, v.es == 3'd2, v.es == 3'd4}));
    $display("[TB] step %0d rl=%b init=%b fe=%b fm=%b -> state=%0d umb=%h ef=%b cfg=%b",
             idx, v.rl, v.ini, v.fe, v.fm, state_out, umbrales_I, error_fifo, cfg_err);
  endtask

  initial begin
    // reset, init capture
    tbl[0]  = mk(0, 0, 2'd0, 8'h00, 4'h0, 5'h00, 5'h1F, 3'd0, 14'h0, 5'h00, 0);
    tbl[1]  = mk(0, 0, 2'd0, 8'h00, 4'h0, 5'h00, 5'h1F, 3'd0, 14'h0, 5'h00, 0);
    tbl[2]  = mk(1, 1, 2'd3, 8'hA5, 4'h9, 5'h00, 5'h1F, 3'd1, 14'h0, 5'h00, 0);
    tbl[3]  = mk(1, 1, 2'd3, 8'hA5, 4'h9, 5'h00, 5'h1F, 3'd1, U1,    5'h00, 0);
    tbl[4]  = mk(1, 0, 2'd3, 8'hA5, 4'h9, 5'h00, 5'h1F, 3'd2, U1,    5'h00, 0);
    // zero VC0 threshold, then clean re-init
    tbl[5]  = mk(1, 1, 2'd3, 8'h50, 4'h9, 5'h00, 5'h1F, 3'd1, U1,    5'h00, 0);
    tbl[6]  = mk(1, 0, 2'd3, 8'h50, 4'h9, 5'h00, 5'h1F, 3'd2, U2,    5'h00, 1);
    tbl[7]  = mk(1, 1, 2'd3, 8'hA5, 4'h9, 5'h00, 5'h1F, 3'd1, U2,    5'h00, 0);
    tbl[8]  = mk(1, 0, 2'd3, 8'hA5, 4'h9, 5'h00, 5'h1F, 3'd2, U1,    5'h00, 0);
    // activity and debounce
    tbl[9]  = mk(1, 0, 2'd3, 8'hA5, 4'h9, 5'h00, 5'h1D, 3'd3, U1,    5'h00, 0);
    tbl[10] = mk(1, 0, 2'd3, 8'hA5, 4'h9, 5'h00, 5'h1F, 3'd3, U1,    5'h00, 0);
    tbl[11] = mk(1, 0, 2'd3, 8'hA5, 4'h9, 5'h00, 5'h1F, 3'd3, U1,    5'h00, 0);
    tbl[12] = mk(1, 0, 2'd3, 8'hA5, 4'h9, 5'h00, 5'h1E, 3'd3, U1,    5'h00, 0);
    tbl[13] = mk(1, 0, 2'd3, 8'hA5, 4'h9, 5'h00, 5'h1F, 3'd3, U1,    5'h00, 0);
    tbl[14] = mk(1, 0, 2'd3, 8'hA5, 4'h9, 5'h00, 5'h1F, 3'd3, U1,    5'h00, 0);
    tbl[15] = mk(1, 0, 2'd3, 8'hA5, 4'h9, 5'h00, 5'h1F, 3'd2, U1,    5'h00, 0);
    tbl[16] = mk(1, 0, 2'd3, 8'hA5, 4'h9, 5'h00, 5'h00, 3'd3, U1,    5'h00, 0);
    // error capture and recovery
    tbl[17] = mk(1, 0, 2'd3, 8'hA5, 4'h9, 5'h04, 5'h00, 3'd4, U1,    5'h04, 0);
    tbl[18] = mk(1, 0, 2'd3, 8'hA5, 4'h9, 5'h00, 5'h00, 3'd4, U1,    5'h04, 0);
    tbl[19] = mk(1, 0, 2'd3, 8'hA5, 4'h9, 5'h10, 5'h00, 3'd4, U1,    5'h14, 0);
    tbl[20] = mk(1, 1, 2'd3, 8'hA5, 4'h9, 5'h01, 5'h00, 3'd4, U1,    5'h15, 0);
    tbl[21] = mk(1, 1, 2'd3, 8'hA5, 4'h9, 5'h00, 5'h00, 3'd1, U1,    5'h00, 0);
    tbl[22] = mk(1, 0, 2'd3, 8'hA5, 4'h9, 5'h00, 5'h1F, 3'd2, U1,    5'h00, 0);
    // simultaneous error, init and activity: error wins
    tbl[23] = mk(1, 1, 2'd3, 8'hA5, 4'h9, 5'h02, 5'h00, 3'd4, U1,    5'h02, 0);
    // reset from ERROR, then back through INIT
    tbl[24] = mk(0, 0, 2'd3, 8'hA5, 4'h9, 5'h00, 5'h1F, 3'd0, 14'h0, 5'h00, 0);
    tbl[25] = mk(1, 0, 2'd3, 8'hA5, 4'h9, 5'h00, 5'h1F, 3'd1, 14'h0, 5'h00, 0);
    tbl[26] = mk(1, 0, 2'd3, 8'hA5, 4'h9, 5'h00, 5'h1F, 3'd2, U1,    5'h00, 0);

    reset_L = 1'b0; init = 1'b0; umbral_MF = '0; umbral_VC = '0; umbral_D = '0;
    FIFO_error = '0; FIFO_empty = 5'h1F;
    #1;

    for (int i = 0; i < 27; i++) begin
      run_vec(tbl[i], i);
    end

    // Error on the edge that would complete the idle debounce: ERROR, not IDLE.
    run_vec(mk(1, 0, 2'd3, 8'hA5, 4'h9, 5'h00, 5'h00, 3'd3, U1, 5'h00, 0), 100);
    run_vec(mk(1, 0, 2'd3, 8'hA5, 4'h9, 5'h00, 5'h1F, 3'd3, U1, 5'h00, 0), 101);
    run_vec(mk(1, 0, 2'd3, 8'hA5, 4'h9, 5'h00, 5'h1F, 3'd3, U1, 5'h00, 0), 102);
    run_vec(mk(1, 0, 2'd3, 8'hA5, 4'h9, 5'h01, 5'h1F, 3'd4, U1, 5'h01, 0), 103);
    // Recovery: INIT does not capture on entry, captures while resident.
    run_vec(mk(1, 1, 2'd1, 8'h11, 4'h5, 5'h00, 5'h1F, 3'd1, U1, 5'h00, 0), 104);
    run_vec(mk(1, 0, 2'd1, 8'h11, 4'h5, 5'h00, 5'h1F, 3'd2, {2'd1, 8'h11, 4'h5}, 5'h00, 0), 105);
    // Zero D1 threshold only.
    run_vec(mk(1, 1, 2'd1, 8'h11, 4'h1, 5'h00, 5'h1F, 3'd1, {2'd1, 8'h11, 4'h5}, 5'h00, 0), 106);
    run_vec(mk(1, 0, 2'd1, 8'h11, 4'h1, 5'h00, 5'h1F, 3'd2, {2'd1, 8'h11, 4'h1}, 5'h00, 1), 107);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
